vtage_wr_sched: RTL and testbench
=================================

// Module: vtage_wr_sched
// PURPOSE
//  Write-port scheduler for the VTAGE component banks. Sits between the update unit and the P_NUM_PRED
//  bank write ports. Buffers update requests in a FIFO and issues up to 2 writes/cycle.
//  Also sequences the periodic usefulness-decay sweep over all bank entries, sharing port 0 with updates.
// PARAMETERS
//  P_NUM_PRED      2     write lanes/ports (design fixed at 2)
//  P_NUM_BANK      4     component banks; LP_BANK_W = $clog2(P_NUM_BANK)
//  P_NUM_ENTRIES   256   entries per bank; LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)
//  P_DATA_WIDTH    48    opaque update payload (ct value/conf/tag/useful)
//  P_FIFO_DEPTH    8     update buffer entries, power of 2, >= 4
//  P_DECAY_PERIOD  1024  issued updates between decay sweeps
//  P_HI_WM         6     FIFO level that pauses a sweep
//  P_LO_WM         2     FIFO level that resumes a paused sweep
// PORTS
//  clk_i         in   1                          main clock
//  rst_ni        in   1                          asynchronous reset, active low
//  upd_valid_i   in   [P_NUM_PRED]               per-lane update request
//  upd_ready_o   out  1                          all lanes accepted this cycle
//  upd_bank_i    in   [P_NUM_PRED][LP_BANK_W]    target bank
//  upd_index_i   in   [P_NUM_PRED][LP_INDEX_WIDTH] target entry
//  upd_data_i    in   [P_NUM_PRED][P_DATA_WIDTH] payload
//  wr_valid_o    out  [P_NUM_PRED]               port write strobe
//  wr_decay_o    out  [P_NUM_PRED]               1 = decay u at wr_index_o in ALL banks, data ignored
//  wr_bank_o     out  [P_NUM_PRED][LP_BANK_W]    bank select (0 when decay)
//  wr_index_o    out  [P_NUM_PRED][LP_INDEX_WIDTH] entry index
//  wr_data_o     out  [P_NUM_PRED][P_DATA_WIDTH] payload
//  sweep_busy_o  out  1                          state != IDLE
//  fifo_level_o  out  [$clog2(P_FIFO_DEPTH):0]   current FIFO occupancy
// BEHAVIOUR
//  Reset (async, rst_ni=0): all wr_* = 0, FIFO empty, state = IDLE, sweep_idx = 0, commit_cnt = 0.
//   Reset mid-sweep abandons the sweep and discards buffered updates.
//  Enqueue: upd_ready_o = (P_FIFO_DEPTH - level) >= 2, computed from current level only.
//   When ready, every valid lane is enqueued; lane 0 is older than lane 1.
//  Issue: all wr_* outputs are registered. An entry enqueued in cycle N appears on wr_* no earlier than N+1.
//   Simultaneous enqueue and dequeue in one cycle is legal at any level.
//  IDLE / PAUSE: head0 -> port 0.
//   head1 -> port 1 unless head1 hits the same bank and index as head0; then head1 waits one cycle.
//   Entries leave in FIFO order only.
//  commit_cnt counts issued updates (+0/1/2) in IDLE only, and saturates.
//   When commit_cnt >= P_DECAY_PERIOD: IDLE -> SWEEP, commit_cnt := 0.
//  SWEEP, port 0 (decay): wr_valid_o[0] = 1, wr_decay_o[0] = 1, wr_index_o[0] = sweep_idx.
//   sweep_idx advances by 1 per decay issued.
//  SWEEP, port 1 (update): issues head0 only.
//  SWEEP conflict: if head0.index == sweep_idx, head0 issues on port 1, the decay stalls (port 0 idle)
//   and sweep_idx holds.
//  SWEEP end: after sweep_idx = P_NUM_ENTRIES-1 issues, -> IDLE and sweep_idx wraps to 0.
//  SWEEP -> PAUSE when level >= P_HI_WM (sampled at cycle start). PAUSE -> SWEEP when level <= P_LO_WM.
//   sweep_idx is held while paused.
//  Empty FIFO: the update ports idle (wr_valid_o = 0). Full FIFO: upd_ready_o = 0, no lane lost.
// STRUCTURE
//  vtage_pkg: upd_entry_t {bank, index, data}, sched_state_e {IDLE, SWEEP, PAUSE}, width localparams.
//  Sub-module vtage_wr_fifo: 2-write / 2-read circular FIFO (wrap-around pointers plus level counter),
//   exposing head0/head1 and a pop count of 0..2.
//  The top holds the FSM, commit_cnt, sweep_idx, hazard compare and output registers.
// TESTING
//  1. Reset, then lane0 {b1,i5} + lane1 {b2,i5} in cycle 0
//     -> cycle 1: both ports valid, b1/i5 on port 0, b2/i5 on port 1.
//  2. Two entries to the same b3,i9
//     -> port 0 in cycle 1, port 1 idle; second entry issues in cycle 2.
//  3. P_DECAY_PERIOD=4, four single updates issued, empty FIFO
//     -> 256 consecutive decay strobes, idx 0..255; sweep_busy_o drops after idx 255; next sweep starts at idx 0.
//  4. Mid-sweep at idx 40, queue an update with index 40
//     -> the update issues on port 1, port 0 idle that cycle, idx 40 decays next cycle.
//  5. Mid-sweep, push the FIFO to 6 -> PAUSE with sweep_idx held and dual-port issue;
//     level drops to 2 -> SWEEP resumes at the held idx.
//  6. Fill the FIFO to 7 -> upd_ready_o = 0.
//     Assert rst_ni low mid-sweep -> all wr_valid_o = 0 immediately, level 0, state IDLE.

Source files
------------

// File: rtl/vtage_wr_sched_pkg.sv
// Shared types and geometry for the VTAGE bank write-port scheduler.
// Bank geometry is fixed here; the scheduler and its FIFO take widths from these constants.
package vtage_wr_sched_pkg;

    localparam int LP_NUM_PRED    = 2;
    localparam int LP_NUM_BANK    = 4;
    localparam int LP_NUM_ENTRIES = 256;
    localparam int LP_DATA_WIDTH  = 48;
    localparam int LP_BANK_W      = $clog2(LP_NUM_BANK);
    localparam int LP_INDEX_WIDTH = $clog2(LP_NUM_ENTRIES);

    typedef struct packed {
        logic [LP_BANK_W-1:0]      bank;
        logic [LP_INDEX_WIDTH-1:0] index;
        logic [LP_DATA_WIDTH-1:0]  data;
    } upd_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        PAUSE = 2'd2
    } sched_state_e;

    // Two updates collide when they target the same physical entry.
    function automatic logic same_slot(input upd_entry_t a, input upd_entry_t b);
        return (a.bank == b.bank) && (a.index == b.index);
    endfunction

endpackage

// File: rtl/vtage_wr_sched_if.sv
// Update-request and bank-write bus between the update unit, the scheduler and the banks.
// master drives update requests; slave is the scheduler side.
interface vtage_wr_sched_if #(
    parameter int P_FIFO_DEPTH = 8
);
    import vtage_wr_sched_pkg::*;

    logic [LP_NUM_PRED-1:0]                     upd_valid_i;
    logic                                       upd_ready_o;
    logic [LP_NUM_PRED-1:0][LP_BANK_W-1:0]      upd_bank_i;
    logic [LP_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] upd_index_i;
    logic [LP_NUM_PRED-1:0][LP_DATA_WIDTH-1:0]  upd_data_i;
    logic [LP_NUM_PRED-1:0]                     wr_valid_o;
    logic [LP_NUM_PRED-1:0]                     wr_decay_o;
    logic [LP_NUM_PRED-1:0][LP_BANK_W-1:0]      wr_bank_o;
    logic [LP_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] wr_index_o;
    logic [LP_NUM_PRED-1:0][LP_DATA_WIDTH-1:0]  wr_data_o;
    logic                                       sweep_busy_o;
    logic [$clog2(P_FIFO_DEPTH):0]              fifo_level_o;

    modport master (
        output upd_valid_i, upd_bank_i, upd_index_i, upd_data_i,
        input  upd_ready_o, wr_valid_o, wr_decay_o, wr_bank_o, wr_index_o, wr_data_o,
        input  sweep_busy_o, fifo_level_o
    );

    modport slave (
        input  upd_valid_i, upd_bank_i, upd_index_i, upd_data_i,
        output upd_ready_o, wr_valid_o, wr_decay_o, wr_bank_o, wr_index_o, wr_data_o,
        output sweep_busy_o, fifo_level_o
    );

endinterface

// File: rtl/vtage_wr_fifo.sv
// Circular update buffer with two write and two read slots per cycle.
// Caller guarantees push_cnt_i never overflows and pop_cnt_i never exceeds level_o.
module vtage_wr_fifo
    import vtage_wr_sched_pkg::*;
#(
    parameter int P_DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [1:0]               push_cnt_i,
    input  upd_entry_t               push0_i,
    input  upd_entry_t               push1_i,
    input  logic [1:0]               pop_cnt_i,
    output upd_entry_t               head0_o,
    output upd_entry_t               head1_o,
    output logic [$clog2(P_DEPTH):0] level_o
);
    localparam int LP_PTR_W = $clog2(P_DEPTH);
    localparam int LP_LVL_W = LP_PTR_W + 1;

    upd_entry_t          mem [P_DEPTH];
    logic [LP_PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr1, rd_ptr1;

    assign wr_ptr1 = wr_ptr + LP_PTR_W'(1);
    assign rd_ptr1 = rd_ptr + LP_PTR_W'(1);
    assign head0_o = mem[rd_ptr];
    assign head1_o = mem[rd_ptr1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            wr_ptr  <= wr_ptr + LP_PTR_W'(push_cnt_i);
            rd_ptr  <= rd_ptr + LP_PTR_W'(pop_cnt_i);
            level_o <= level_o + LP_LVL_W'(push_cnt_i) - LP_LVL_W'(pop_cnt_i);
        end
    end

    // Payload storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk_i) begin
        if (push_cnt_i != 2'd0) mem[wr_ptr]  <= push0_i;
        if (push_cnt_i == 2'd2) mem[wr_ptr1] <= push1_i;
    end

endmodule

// File: rtl/vtage_wr_sched.sv
// VTAGE bank write-port scheduler: buffers updates, issues up to two writes per cycle
// and interleaves the periodic usefulness-decay sweep on port 0.
module vtage_wr_sched
    import vtage_wr_sched_pkg::*;
#(
    parameter int P_FIFO_DEPTH   = 8,
    parameter int P_DECAY_PERIOD = 1024,
    parameter int P_HI_WM        = 6,
    parameter int P_LO_WM        = 2
) (
    input logic             clk_i,
    input logic             rst_ni,
    vtage_wr_sched_if.slave bus
);
    localparam int LP_LVL_W = $clog2(P_FIFO_DEPTH) + 1;
    localparam int LP_CNT_W = $clog2(P_DECAY_PERIOD + 2) + 1;
    localparam logic [LP_CNT_W-1:0]       LP_CNT_MAX  = '1;
    localparam logic [LP_INDEX_WIDTH-1:0] LP_LAST_IDX = LP_INDEX_WIDTH'(LP_NUM_ENTRIES - 1);

    sched_state_e                state_q, state_d;
    logic [LP_CNT_W-1:0]         commit_cnt_q, commit_cnt_d;
    logic [LP_INDEX_WIDTH-1:0]   sweep_idx_q, sweep_idx_d;
    logic [LP_LVL_W-1:0]         level;
    upd_entry_t                  lane [LP_NUM_PRED];
    upd_entry_t                  push0, push1, head0, head1;
    logic [1:0]                  push_cnt, pop_cnt;
    logic                        ready, h0_vld, h1_vld, conflict;

    logic [LP_NUM_PRED-1:0]                     wr_valid_p0, wr_valid_p1;
    logic [LP_NUM_PRED-1:0]                     wr_decay_p0, wr_decay_p1;
    logic [LP_NUM_PRED-1:0][LP_BANK_W-1:0]      wr_bank_p0, wr_bank_p1;
    logic [LP_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0] wr_index_p0, wr_index_p1;
    logic [LP_NUM_PRED-1:0][LP_DATA_WIDTH-1:0]  wr_data_p0, wr_data_p1;

    function automatic logic [LP_CNT_W-1:0] sat_add(input logic [LP_CNT_W-1:0] a,
                                                    input logic [1:0] b);
        logic [LP_CNT_W:0] s;
        s = {1'b0, a} + (LP_CNT_W + 1)'(b);
        return s[LP_CNT_W] ? LP_CNT_MAX : s[LP_CNT_W-1:0];
    endfunction

    assign ready    = (P_FIFO_DEPTH - int'(level)) >= 2;
    assign h0_vld   = (level != '0);
    assign h1_vld   = (int'(level) >= 2);
    assign conflict = h0_vld && (head0.index == sweep_idx_q);

    // Stage p0: compact the valid lanes so the FIFO always sees lane 0 before lane 1.
    always_comb begin
        for (int i = 0; i < LP_NUM_PRED; i++) begin
            lane[i].bank  = bus.upd_bank_i[i];
            lane[i].index = bus.upd_index_i[i];
            lane[i].data  = bus.upd_data_i[i];
        end
        push0    = lane[0];
        push1    = lane[1];
        push_cnt = 2'd0;
        if (ready) begin
            unique case (bus.upd_valid_i)
                2'b01:   push_cnt = 2'd1;
                2'b10: begin
                    push_cnt = 2'd1;
                    push0    = lane[1];
                end
                2'b11:   push_cnt = 2'd2;
                default: push_cnt = 2'd0;
            endcase
        end
    end

    vtage_wr_fifo #(
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_cnt_i (push_cnt),
        .push0_i    (push0),
        .push1_i    (push1),
        .pop_cnt_i  (pop_cnt),
        .head0_o    (head0),
        .head1_o    (head1),
        .level_o    (level)
    );

    always_comb begin
        wr_valid_p0  = '0;
        wr_decay_p0  = '0;
        wr_bank_p0   = '0;
        wr_index_p0  = '0;
        wr_data_p0   = '0;
        pop_cnt      = 2'd0;
        state_d      = state_q;
        commit_cnt_d = commit_cnt_q;
        sweep_idx_d  = sweep_idx_q;
        unique case (state_q)
            SWEEP: begin
                if (h0_vld) begin
                    wr_valid_p0[1] = 1'b1;
                    wr_bank_p0[1]  = head0.bank;
                    wr_index_p0[1] = head0.index;
                    wr_data_p0[1]  = head0.data;
                    pop_cnt        = 2'd1;
                end
                // An update to the entry about to decay goes first; the decay retries next cycle.
                if (!conflict) begin
                    wr_valid_p0[0] = 1'b1;
                    wr_decay_p0[0] = 1'b1;
                    wr_index_p0[0] = sweep_idx_q;
                end
                if (!conflict && (sweep_idx_q == LP_LAST_IDX)) begin
                    state_d     = IDLE;
                    sweep_idx_d = '0;
                end else begin
                    if (!conflict) sweep_idx_d = sweep_idx_q + LP_INDEX_WIDTH'(1);
                    if (int'(level) >= P_HI_WM) state_d = PAUSE;
                end
            end
            default: begin
                if (h0_vld) begin
                    wr_valid_p0[0] = 1'b1;
                    wr_bank_p0[0]  = head0.bank;
                    wr_index_p0[0] = head0.index;
                    wr_data_p0[0]  = head0.data;
                    pop_cnt        = 2'd1;
                end
                if (h1_vld && !same_slot(head0, head1)) begin
                    wr_valid_p0[1] = 1'b1;
                    wr_bank_p0[1]  = head1.bank;
                    wr_index_p0[1] = head1.index;
                    wr_data_p0[1]  = head1.data;
                    pop_cnt        = 2'd2;
                end
                if (state_q == IDLE) begin
                    if (int'(commit_cnt_q) >= P_DECAY_PERIOD) begin
                        state_d      = SWEEP;
                        commit_cnt_d = '0;
                    end else begin
                        commit_cnt_d = sat_add(commit_cnt_q, pop_cnt);
                    end
                end else if (int'(level) <= P_LO_WM) begin
                    state_d = SWEEP;
                end
            end
        endcase
    end

    // Stage p1: registered control state and write-port outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            commit_cnt_q <= '0;
            sweep_idx_q  <= '0;
            wr_valid_p1  <= '0;
            wr_decay_p1  <= '0;
            wr_bank_p1   <= '0;
            wr_index_p1  <= '0;
            wr_data_p1   <= '0;
        end else begin
            state_q      <= state_d;
            commit_cnt_q <= commit_cnt_d;
            sweep_idx_q  <= sweep_idx_d;
            wr_valid_p1  <= wr_valid_p0;
            wr_decay_p1  <= wr_decay_p0;
            wr_bank_p1   <= wr_bank_p0;
            wr_index_p1  <= wr_index_p0;
            wr_data_p1   <= wr_data_p0;
        end
    end

    assign bus.upd_ready_o  = ready;
    assign bus.wr_valid_o   = wr_valid_p1;
    assign bus.wr_decay_o   = wr_decay_p1;
    assign bus.wr_bank_o    = wr_bank_p1;
    assign bus.wr_index_o   = wr_index_p1;
    assign bus.wr_data_o    = wr_data_p1;
    assign bus.sweep_busy_o = (state_q != IDLE);
    assign bus.fifo_level_o = level;

endmodule

// File: tb/tb_vtage_wr_sched.sv
// Bench for vtage_wr_sched: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vtage_wr_sched;
    localparam int DEPTH  = 8;
    localparam int PERIOD = 4;
    localparam int HI     = 6;
    localparam int LO     = 2;

    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    vtage_wr_sched_if #(.P_FIFO_DEPTH(DEPTH)) bus ();

    vtage_wr_sched #(
        .P_FIFO_DEPTH   (DEPTH),
        .P_DECAY_PERIOD (PERIOD),
        .P_HI_WM        (HI),
        .P_LO_WM        (LO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending updates plus sweep mode/position.
    typedef struct {
        logic [1:0]  bank;
        logic [7:0]  idx;
        logic [47:0] data;
    } ment_t;

    ment_t       q[$];
    ment_t       e;
    int          m_mode;   // 0 idle, 1 sweeping, 2 paused
    int          m_cnt;
    int          m_sidx;
    int          m_lvl;
    int          m_npop;
    bit          m_dec;
    logic [1:0]  m_valid, m_decay;
    logic [1:0]  m_bank  [2];
    logic [7:0]  m_index [2];
    logic [47:0] m_data  [2];

    task automatic m_put(input int p, input ment_t x);
        m_valid[p] = 1'b1;
        m_bank[p]  = x.bank;
        m_index[p] = x.idx;
        m_data[p]  = x.data;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_mode = 0; m_cnt = 0; m_sidx = 0;
            m_valid = '0; m_decay = '0;
            for (int p = 0; p < 2; p++) begin
                m_bank[p] = '0; m_index[p] = '0; m_data[p] = '0;
            end
        end else begin
            m_lvl = q.size(); m_npop = 0; m_dec = 0;
            m_valid = '0; m_decay = '0;
            for (int p = 0; p < 2; p++) begin
                m_bank[p] = '0; m_index[p] = '0; m_data[p] = '0;
            end
            if (m_mode == 1) begin
                if (m_lvl > 0) begin
                    m_put(1, q[0]);
                    m_npop = 1;
                end
                if (!(m_lvl > 0 && int'(q[0].idx) == m_sidx)) begin
                    m_dec = 1;
                    m_valid[0] = 1'b1; m_decay[0] = 1'b1; m_index[0] = 8'(m_sidx);
                end
            end else if (m_lvl > 0) begin
                m_put(0, q[0]);
                m_npop = 1;
                if (m_lvl > 1 && !(q[1].bank == q[0].bank && q[1].idx == q[0].idx)) begin
                    m_put(1, q[1]);
                    m_npop = 2;
                end
            end
            case (m_mode)
                0: if (m_cnt >= PERIOD) begin m_mode = 1; m_cnt = 0; end
                   else m_cnt = m_cnt + m_npop;
                1: if (m_dec && m_sidx == 255) begin m_mode = 0; m_sidx = 0; end
                   else begin
                       if (m_dec) m_sidx++;
                       if (m_lvl >= HI) m_mode = 2;
                   end
                default: if (m_lvl <= LO) m_mode = 1;
            endcase
            for (int k = 0; k < m_npop; k++) void'(q.pop_front());
            if (DEPTH - m_lvl >= 2) begin
                for (int l = 0; l < 2; l++) begin
                    if (bus.upd_valid_i[l]) begin
                        e.bank = bus.upd_bank_i[l]; e.idx = bus.upd_index_i[l]; e.data = bus.upd_data_i[l];
                        q.push_back(e);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("wr_valid", bus.wr_valid_o, m_valid);
            chk("wr_decay", bus.wr_decay_o, m_decay);
            for (int p = 0; p < 2; p++) begin
                if (m_valid[p]) begin
                    chk("wr_bank", bus.wr_bank_o[p], m_bank[p]);
                    chk("wr_index", bus.wr_index_o[p], m_index[p]);
                    chk("wr_data", bus.wr_data_o[p], m_data[p]);
                end
            end
            chk("upd_ready", bus.upd_ready_o, (DEPTH - q.size()) >= 2);
            chk("fifo_level", bus.fifo_level_o, q.size());
            chk("sweep_busy", bus.sweep_busy_o, m_mode != 0);
        end
    end

    task automatic lane(input int l, input logic [1:0] b, input logic [7:0] i, input logic [47:0] d);
        bus.upd_valid_i[l] = 1'b1;
        bus.upd_bank_i[l]  = b;
        bus.upd_index_i[l] = i;
        bus.upd_data_i[l]  = d;
    endtask

    task automatic idle_lanes();
        bus.upd_valid_i = '0;
    endtask

    task automatic do_reset();
        idle_lanes();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns at the negedge where port 0 shows a decay (of index idx, or any when idx < 0).
    task automatic wait_decay(input int idx, input int max, output bit ok);
        ok = 0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (bus.wr_valid_o[0] && bus.wr_decay_o[0] && (idx < 0 || int'(bus.wr_index_o[0]) == idx)) begin
                ok = 1;
                return;
            end
        end
    endtask

    task automatic single_updates(input logic [7:0] base);
        for (int k = 0; k < 4; k++) begin
            idle_lanes();
            lane(0, 2'd0, base + 8'(k), 48'(k));
            @(negedge clk);
        end
        idle_lanes();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    bit ok, seq_ok, dual, resumed, busy_ok, found;
    int n, last;

    initial begin
        clk = 0; rst_n = 0;
        bus.upd_valid_i = '0; bus.upd_bank_i = '0; bus.upd_index_i = '0; bus.upd_data_i = '0;
        @(negedge clk);
        do_reset();
        chk("rst_valid", bus.wr_valid_o, 2'b00);
        chk("rst_level", bus.fifo_level_o, 0);
        chk("rst_busy", bus.sweep_busy_o, 0);
        chk("rst_ready", bus.upd_ready_o, 1);

        // Two lanes, different banks, same index: both ports one cycle later.
        lane(0, 2'd1, 8'd5, 48'h11); lane(1, 2'd2, 8'd5, 48'h22);
        @(negedge clk); idle_lanes();
        @(negedge clk);
        chk("t1_valid", bus.wr_valid_o, 2'b11);
        chk("t1_bank0", bus.wr_bank_o[0], 1);
        chk("t1_idx0", bus.wr_index_o[0], 5);
        chk("t1_bank1", bus.wr_bank_o[1], 2);
        chk("t1_idx1", bus.wr_index_o[1], 5);
        chk("t1_data1", bus.wr_data_o[1], 48'h22);

        // Same bank+index pair: second entry waits one cycle.
        do_reset();
        lane(0, 2'd3, 8'd9, 48'hA); lane(1, 2'd3, 8'd9, 48'hB);
        @(negedge clk); idle_lanes();
        @(negedge clk);
        chk("t2_valid_c1", bus.wr_valid_o, 2'b01);
        chk("t2_data_c1", bus.wr_data_o[0], 48'hA);
        @(negedge clk);
        chk("t2_valid_c2", bus.wr_valid_o, 2'b01);
        chk("t2_bank_c2", bus.wr_bank_o[0], 3);
        chk("t2_data_c2", bus.wr_data_o[0], 48'hB);

        // Four issued updates trigger a full 256-entry sweep.
        do_reset();
        single_updates(8'd100);
        wait_decay(-1, 40, ok);
        chk("t3_sweep_start", ok, 1);
        chk("t3_first_idx", bus.wr_index_o[0], 0);
        n = 0; seq_ok = 1;
        while (ok && n < 256) begin
            if (!(bus.wr_valid_o[0] && bus.wr_decay_o[0])) break;
            if (int'(bus.wr_index_o[0]) != n) seq_ok = 0;
            if (n == 254) chk("t3_busy_254", bus.sweep_busy_o, 1);
            if (n == 255) chk("t3_busy_255", bus.sweep_busy_o, 0);
            n++;
            if (n < 256) @(negedge clk);
        end
        chk("t3_decay_count", n, 256);
        chk("t3_decay_seq", seq_ok, 1);
        @(negedge clk);
        chk("t3_after_sweep", bus.wr_valid_o[0], 0);
        single_updates(8'd110);
        wait_decay(-1, 40, ok);
        chk("t3_second_sweep", ok, 1);
        chk("t3_second_idx", bus.wr_index_o[0], 0);

        // Update to the entry about to decay: it takes port 1, decay slips one cycle.
        wait_decay(38, 60, ok);
        chk("t4_reach_38", ok, 1);
        lane(0, 2'd1, 8'd40, 48'h40);
        @(negedge clk); idle_lanes();
        chk("t4_decay_39", bus.wr_index_o[0], 39);
        @(negedge clk);
        chk("t4_conflict_valid", bus.wr_valid_o, 2'b10);
        chk("t4_conflict_idx1", bus.wr_index_o[1], 40);
        chk("t4_conflict_data1", bus.wr_data_o[1], 48'h40);
        @(negedge clk);
        chk("t4_late_decay", {bus.wr_valid_o[0], bus.wr_decay_o[0]}, 2'b11);
        chk("t4_late_idx", bus.wr_index_o[0], 40);

        // Build the level to 6 mid-sweep: pause with dual issue, then resume at the held index.
        last = -1; dual = 0; resumed = 0; busy_ok = 1;
        for (int k = 0; k < 5; k++) begin
            lane(0, 2'd1, 8'(200 + 2 * k), 48'(k)); lane(1, 2'd1, 8'(201 + 2 * k), 48'(k + 16));
            @(negedge clk);
            if (bus.wr_valid_o[0] && bus.wr_decay_o[0]) last = int'(bus.wr_index_o[0]);
        end
        idle_lanes();
        chk("t5_level_6", bus.fifo_level_o, 6);
        for (int c = 0; c < 20 && !resumed; c++) begin
            @(negedge clk);
            if (!bus.sweep_busy_o) busy_ok = 0;
            if (bus.wr_valid_o == 2'b11 && bus.wr_decay_o == 2'b00) dual = 1;
            if (bus.wr_valid_o[0] && bus.wr_decay_o[0]) begin
                if (dual) begin
                    chk("t5_resume_idx", bus.wr_index_o[0], last + 1);
                    resumed = 1;
                end else begin
                    last = int'(bus.wr_index_o[0]);
                end
            end
        end
        chk("t5_dual_issue", dual, 1);
        chk("t5_resumed", resumed, 1);
        chk("t5_busy_held", busy_ok, 1);

        // Same-slot pairs drain one per cycle: level climbs to 7 and ready drops.
        found = 0;
        for (int c = 0; c < 30; c++) begin
            lane(0, 2'd2, 8'd222, 48'(c)); lane(1, 2'd2, 8'd222, 48'(c + 100));
            @(negedge clk);
            if (bus.fifo_level_o == 7) begin
                found = 1;
                break;
            end
        end
        idle_lanes();
        chk("t6_reach_7", found, 1);
        chk("t6_ready_full", bus.upd_ready_o, 0);
        chk("t6_busy", bus.sweep_busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.wr_valid_o, 2'b00);
        chk("t6_rst_level", bus.fifo_level_o, 0);
        chk("t6_rst_busy", bus.sweep_busy_o, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_post_valid", bus.wr_valid_o, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
